sha256_digest_tx: RTL and testbench

SHA256_DIGEST_TX -- requirements
Module: sha256_digest_tx

---
 rtl/sha256_digest_tx_if.sv | 21 ++
 rtl/sha256_digest_tx.sv | 107 ++++++++++
 tb/tb_sha256_digest_tx.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_digest_tx_if.sv
// rtl/sha256_digest_tx_if.sv - digest input and byte-stream output bundle for sha256_digest_tx
interface sha256_digest_tx_if;
    logic [255:0] hash_i;
    logic         hash_vld_i;
    logic [7:0]   byte_o;
    logic         byte_vld_o;
    logic         byte_rdy_i;
    logic         busy_o;
    logic         done_o;
    logic         drop_o;

    modport master (
        input  hash_i, hash_vld_i, byte_rdy_i,
        output byte_o, byte_vld_o, busy_o, done_o, drop_o
    );

    modport slave (
        output hash_i, hash_vld_i, byte_rdy_i,
        input  byte_o, byte_vld_o, busy_o, done_o, drop_o
    );
endinterface

// File: rtl/sha256_digest_tx.sv
// rtl/sha256_digest_tx.sv - serialises a 256-bit digest as raw bytes or lowercase hex text
// The shift register always holds the current byte/nibble at its top, so byte_o is a registered copy.
module sha256_digest_tx #(
    parameter int HEX_ASCII = 0,
    parameter int APPEND_NL = 0
) (
    input  logic              clk,
    input  logic              rst,
    sha256_digest_tx_if.master bus
);
    localparam int         N_XFER = ((HEX_ASCII != 0) ? 64 : 32) + ((APPEND_NL != 0) ? 1 : 0);
    localparam int         STEP   = (HEX_ASCII != 0) ? 4 : 8;
    localparam logic [6:0] LAST   = 7'(N_XFER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [255:0] sr;
    logic [255:0] sr_shift;
    logic [6:0]   cnt;
    logic [6:0]   cnt_next;
    logic         prev_vld;
    logic         start;
    logic [7:0]   byte_q;
    logic         vld_q;
    logic         busy_q;
    logic         done_q;
    logic         drop_q;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] n;
        n = {4'h0, nib};
        return (nib < 4'd10) ? (8'h30 + n) : (8'h57 + n);
    endfunction

    function automatic logic [7:0] encode(input logic [255:0] v);
        if (HEX_ASCII != 0)
            return hex_char(v[255:252]);
        else
            return v[255:248];
    endfunction

    assign start    = bus.hash_vld_i & ~prev_vld;
    assign sr_shift = sr << STEP;
    assign cnt_next = cnt + 7'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            prev_vld <= 1'b0;
            byte_q   <= '0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            prev_vld <= bus.hash_vld_i;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= SEND;
                        sr     <= bus.hash_i;
                        cnt    <= '0;
                        byte_q <= encode(bus.hash_i);
                        vld_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SEND: begin
                    // A new edge mid-message is reported but never disturbs the bytes in flight.
                    if (start)
                        drop_q <= 1'b1;
                    if (bus.byte_rdy_i) begin
                        if (cnt == LAST) begin
                            state  <= DONE;
                            vld_q  <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            cnt    <= cnt_next;
                            sr     <= sr_shift;
                            byte_q <= ((APPEND_NL != 0) && (cnt_next == LAST)) ? 8'h0a
                                                                              : encode(sr_shift);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.byte_o     = byte_q;
    assign bus.byte_vld_o = vld_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.drop_o     = drop_q;
endmodule

// File: tb/tb_sha256_digest_tx.sv
// tb/tb_sha256_digest_tx.sv - bench for sha256_digest_tx, raw and hex+newline instances side by side
module tb_sha256_digest_tx;
    localparam logic [255:0] ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    logic         clk = 1'b0;
    logic         rst;
    logic         hash_vld;
    logic         rdy;
    logic [255:0] hash;

    always #5 clk = ~clk;

    sha256_digest_tx_if if_raw();
    sha256_digest_tx_if if_hex();

    assign if_raw.hash_i     = hash;
    assign if_raw.hash_vld_i = hash_vld;
    assign if_raw.byte_rdy_i = rdy;
    assign if_hex.hash_i     = hash;
    assign if_hex.hash_vld_i = hash_vld;
    assign if_hex.byte_rdy_i = rdy;

    sha256_digest_tx #(.HEX_ASCII(0), .APPEND_NL(0)) u_raw (.clk(clk), .rst(rst), .bus(if_raw));
    sha256_digest_tx #(.HEX_ASCII(1), .APPEND_NL(1)) u_hex (.clk(clk), .rst(rst), .bus(if_hex));

    logic [7:0] d_byte [2];
    logic       d_vld  [2];
    logic       d_busy [2];
    logic       d_done [2];
    logic       d_drop [2];

    assign d_byte[0] = if_raw.byte_o;
    assign d_vld[0]  = if_raw.byte_vld_o;
    assign d_busy[0] = if_raw.busy_o;
    assign d_done[0] = if_raw.done_o;
    assign d_drop[0] = if_raw.drop_o;
    assign d_byte[1] = if_hex.byte_o;
    assign d_vld[1]  = if_hex.byte_vld_o;
    assign d_busy[1] = if_hex.busy_o;
    assign d_done[1] = if_hex.done_o;
    assign d_drop[1] = if_hex.drop_o;

    int checks = 0;
    int errors = 0;

    // Model: queue of bytes still owed by each instance (front = byte on the wire).
    logic [7:0] mq    [2][$];
    logic       mprev [2] = '{1'b0, 1'b0};
    logic       mdone [2] = '{1'b0, 1'b0};
    logic       mdrop [2] = '{1'b0, 1'b0};
    logic       mrst  [2] = '{1'b1, 1'b1};

    int         tx_cnt   [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    int         drop_cnt [2] = '{0, 0};
    logic [7:0] log_b    [2][$];

    int b_tx [2];
    int b_done [2];
    int b_drop [2];
    int b_log [2];

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", nm, m, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        return 8'h61 + ({4'h0, n} - 8'd10);
    endfunction

    task automatic load(input int m, input logic [255:0] h);
        logic [7:0] b;
        mq[m].delete();
        for (int k = 0; k < 32; k++) begin
            b = h[255 - 8*k -: 8];
            if (m == 0) begin
                mq[m].push_back(b);
            end else begin
                mq[m].push_back(hexc(b[7:4]));
                mq[m].push_back(hexc(b[3:0]));
            end
        end
        if (m == 1)
            mq[m].push_back(8'h0a);
    endtask

    always @(negedge clk) begin
        logic ev;
        logic st;
        for (int m = 0; m < 2; m++) begin
            ev = (mq[m].size() > 0);
            chk("byte_vld", m, 32'(d_vld[m]), 32'(ev));
            chk("busy", m, 32'(d_busy[m]), 32'(ev));
            chk("done", m, 32'(d_done[m]), 32'(mdone[m]));
            chk("drop", m, 32'(d_drop[m]), 32'(mdrop[m]));
            if (ev)
                chk("byte", m, 32'(d_byte[m]), 32'(mq[m][0]));
            if (mrst[m])
                chk("reset_byte", m, 32'(d_byte[m]), 32'h0);
            if (d_vld[m] && rdy && rst) begin
                tx_cnt[m]++;
                log_b[m].push_back(d_byte[m]);
            end
            if (d_done[m])
                done_cnt[m]++;
            if (d_drop[m])
                drop_cnt[m]++;

            mrst[m] = 1'b0;
            if (!rst) begin
                mq[m].delete();
                mprev[m] = 1'b0;
                mdone[m] = 1'b0;
                mdrop[m] = 1'b0;
                mrst[m]  = 1'b1;
            end else begin
                st       = hash_vld && !mprev[m];
                mprev[m] = hash_vld;
                mdone[m] = 1'b0;
                mdrop[m] = 1'b0;
                if (mq[m].size() > 0) begin
                    if (st)
                        mdrop[m] = 1'b1;
                    if (rdy) begin
                        void'(mq[m].pop_front());
                        if (mq[m].size() == 0)
                            mdone[m] = 1'b1;
                    end
                end else if (st) begin
                    load(m, hash);
                end
            end
        end
    end

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rdy(input int bp);
        rdy = (bp != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic snap();
        for (int m = 0; m < 2; m++) begin
            b_tx[m]   = tx_cnt[m];
            b_done[m] = done_cnt[m];
            b_drop[m] = drop_cnt[m];
            b_log[m]  = log_b[m].size();
        end
    endtask

    task automatic start_msg(input logic [255:0] h, input int bp);
        hash     = h;
        hash_vld = 1'b1;
        drive_rdy(bp);
        step();
        hash_vld = 1'b0;
    endtask

    task automatic wait_idle(input int bp);
        int n;
        n = 0;
        while ((mq[0].size() > 0 || mq[1].size() > 0 || mdone[0] || mdone[1]) && n < 3000) begin
            drive_rdy(bp);
            if (bp != 0)
                hash = rand256();
            step();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle got %0d cycles expected under 3000", n);
        end
    endtask

    task automatic wait_tx(input int target);
        int n;
        n = 0;
        while (tx_cnt[0] - b_tx[0] < target && n < 500) begin
            rdy = 1'b1;
            step();
            n++;
        end
        chk("wait_tx", 0, 32'(tx_cnt[0] - b_tx[0]), 32'(target));
    endtask

    task automatic chk_msg(input string nm, input int n_raw, input int n_hex, input int d_raw, input int d_hex);
        chk({nm, "_tx"}, 0, 32'(tx_cnt[0] - b_tx[0]), 32'(n_raw));
        chk({nm, "_tx"}, 1, 32'(tx_cnt[1] - b_tx[1]), 32'(n_hex));
        chk({nm, "_done"}, 0, 32'(done_cnt[0] - b_done[0]), 32'(d_raw));
        chk({nm, "_done"}, 1, 32'(done_cnt[1] - b_done[1]), 32'(d_hex));
    endtask

    initial begin
        int n;
        rst      = 1'b0;
        hash_vld = 1'b0;
        rdy      = 1'b0;
        hash     = '0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // Known "abc" digest, sink always ready.
        snap();
        start_msg(ABC, 0);
        wait_idle(0);
        chk_msg("abc", 32, 65, 1, 1);
        chk("abc_b0", 0, 32'(log_b[0][b_log[0]]), 32'hba);
        chk("abc_b1", 0, 32'(log_b[0][b_log[0] + 1]), 32'h78);
        chk("abc_b31", 0, 32'(log_b[0][b_log[0] + 31]), 32'had);
        chk("abc_c0", 1, 32'(log_b[1][b_log[1]]), 32'h62);
        chk("abc_c1", 1, 32'(log_b[1][b_log[1] + 1]), 32'h61);
        chk("abc_c2", 1, 32'(log_b[1][b_log[1] + 2]), 32'h37);
        chk("abc_c62", 1, 32'(log_b[1][b_log[1] + 62]), 32'h61);
        chk("abc_c63", 1, 32'(log_b[1][b_log[1] + 63]), 32'h64);
        chk("abc_c64", 1, 32'(log_b[1][b_log[1] + 64]), 32'h0a);

        // Same digest under random backpressure.
        snap();
        start_msg(ABC, 1);
        wait_idle(1);
        chk_msg("bp", 32, 65, 1, 1);
        chk("bp_b0", 0, 32'(log_b[0][b_log[0]]), 32'hba);
        chk("bp_b31", 0, 32'(log_b[0][b_log[0] + 31]), 32'had);

        // Random digests, random ready, hash_i scrambled after capture.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) begin
                drive_rdy(1);
                step();
            end
            snap();
            start_msg(rand256(), 1);
            wait_idle(1);
            chk_msg("rnd", 32, 65, 1, 1);
        end

        // Second edge at raw transfer 10 is dropped.
        snap();
        start_msg(rand256(), 0);
        wait_tx(10);
        hash_vld = 1'b1;
        step();
        hash_vld = 1'b0;
        wait_idle(0);
        chk_msg("drop", 32, 65, 1, 1);
        chk("drop_cnt", 0, 32'(drop_cnt[0] - b_drop[0]), 32'd1);
        chk("drop_cnt", 1, 32'(drop_cnt[1] - b_drop[1]), 32'd1);

        // One-cycle reset at raw transfer 5 aborts without done.
        snap();
        start_msg(rand256(), 0);
        wait_tx(5);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_vld", 0, 32'(d_vld[0]), 32'h0);
        chk("abort_busy", 1, 32'(d_busy[1]), 32'h0);
        repeat (3) step();
        chk("abort_done", 0, 32'(done_cnt[0] - b_done[0]), 32'd0);
        chk("abort_done", 1, 32'(done_cnt[1] - b_done[1]), 32'd0);
        snap();
        start_msg(ABC, 0);
        wait_idle(0);
        chk_msg("after_rst", 32, 65, 1, 1);
        chk("after_rst_b0", 0, 32'(log_b[0][b_log[0]]), 32'hba);
        chk("after_rst_b31", 0, 32'(log_b[0][b_log[0] + 31]), 32'had);

        // Held level sends once; an edge in the DONE cycle restarts with no gap.
        snap();
        hash     = ABC;
        hash_vld = 1'b1;
        repeat (200) begin
            rdy = 1'b1;
            step();
        end
        chk_msg("held", 32, 65, 1, 1);
        hash_vld = 1'b0;
        step();
        hash_vld = 1'b1;
        step();
        hash_vld = 1'b0;
        n = 0;
        while (!mdone[0] && n < 200) begin
            step();
            n++;
        end
        hash_vld = 1'b1;
        step();
        chk("b2b_vld", 0, 32'(d_vld[0]), 32'h1);
        chk("b2b_busy", 0, 32'(d_busy[0]), 32'h1);
        hash_vld = 1'b0;
        wait_idle(0);
        chk_msg("b2b", 96, 130, 3, 2);
        chk("b2b_drop", 1, 32'(drop_cnt[1] - b_drop[1]), 32'd1);

        // hash_vld already high when reset releases.
        rst      = 1'b0;
        hash_vld = 1'b1;
        hash     = rand256();
        step();
        snap();
        rst = 1'b1;
        step();
        hash_vld = 1'b0;
        wait_idle(0);
        chk_msg("rst_edge", 32, 65, 1, 1);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
